shift_seq_ctrl: RTL

- Multi-cycle 16-bit shifter/rotator built around one shared shift stage, reused once per cycle.
- Shift amount 0-15 is decomposed into power-of-two stages: 8, 4, 2, 1.
- Accepts one request via valid/ready, sequences the stage, and presents the result via valid/ready.
- Sits between the ALU issue logic and writeback, replacing a full 4-level barrel shifter where area matters.

---
 rtl/shift_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle 16-bit shifter/rotator with a single shared shift stage.
// The shift amount is applied one power-of-two stage per clock (8, 4, 2, 1), from the
// highest stage down. Request and result each use a valid/ready handshake.
// Optional build macro SHIFT_SEQ_SKIP_EN: RUN visits only the stages whose amount bit is
// set, so latency becomes max(popcount(amt), 1). Results are the same in both builds.
module shift_seq_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_op,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned STG_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        op_q, op_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [STG_W-1:0]  stage_q, stage_d;

  logic              accept;
  logic [DATA_W-1:0] stage_res;
  logic [STG_W-1:0]  start_stage;
  logic [STG_W-1:0]  next_stage;
  logic              next_found;

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_data  = data_q;
  // A finished result retiring this cycle frees the block for a new request.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  // Shared shift stage: shifts the held data by 2**stage according to the held op.
  always_comb begin
    int unsigned sh;
    sh        = 32'd1 << stage_q;
    stage_res = data_q;
    case (op_q)
      OP_ROL: stage_res = (data_q << sh) | (data_q >> (DATA_W - sh));
      OP_SLL: stage_res = data_q << sh;
      OP_SRA: stage_res = $signed(data_q) >>> sh;
      OP_SRL: stage_res = data_q >> sh;
      default: stage_res = data_q;
    endcase
  end

  // Stage scheduling: where RUN starts and which stage follows the current one.
  always_comb begin
    next_found = 1'b0;
    next_stage = '0;
`ifdef SHIFT_SEQ_SKIP_EN
    // Highest set amount bit; zero amount still takes one (no-op) pass through RUN.
    start_stage = '0;
    for (int k = 0; k < int'(AMT_W); k++) begin
      if (in_amt[k]) start_stage = STG_W'(k);
    end
    // Highest set bit strictly below the current stage.
    for (int k = 0; k < int'(AMT_W); k++) begin
      if ((k < int'(stage_q)) && amt_q[k]) begin
        next_stage = STG_W'(k);
        next_found = 1'b1;
      end
    end
`else
    start_stage = STG_W'(AMT_W - 1);
    if (stage_q != '0) begin
      next_stage = stage_q - 1'b1;
      next_found = 1'b1;
    end
`endif
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    amt_d   = amt_q;
    stage_d = stage_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          data_d  = in_data;
          op_d    = in_op;
          amt_d   = in_amt;
          stage_d = start_stage;
          state_d = RUN;
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (amt_q[stage_q]) data_d = stage_res;
        if (next_found) stage_d = next_stage;
        else            state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
    end
  end

endmodule
